// File: rtl/window_5x5_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : window_5x5_gen_pkg
// Description : Shared filter-stage definitions: window geometry, window
//               bit-offset helper and the 5x5 Sobel Y kernel coefficients.
// Revision    : 1.0 - initial release
// ============================================================================
package window_5x5_gen_pkg;

   localparam int WIN_DIM      = 5;
   localparam int WIN_PIX      = WIN_DIM * WIN_DIM;
   localparam int PIX_BITS_DEF = 8;

   // 5x5 Sobel Y coefficients, row-major, row 0 = top (oldest) line.
   // Every row sums to a value whose weighted column total is zero, so a
   // flat image gives a zero response.
   localparam int SOBEL_Y_5X5 [WIN_PIX] = '{
       1,  4,   6,  4,  1,
       2,  8,  12,  8,  2,
       0,  0,   0,  0,  0,
      -2, -8, -12, -8, -2,
      -1, -4,  -6, -4, -1
   };

   // Bit offset of window element (row r, column c) in the packed window.
   function automatic int win_idx(input int r, input int c,
                                  input int pix_w = PIX_BITS_DEF);
      return (r * WIN_DIM + c) * pix_w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/window_5x5_gen_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : window_5x5_gen_line_buffer
// Description : One image line of pixel storage. Asynchronous read and
//               synchronous write at the same column address, so a chain of
//               these shifts a column down by one line per write.
// Revision    : 1.0 - initial release
// ============================================================================
module window_5x5_gen_line_buffer #(
   parameter int IMG_WIDTH = 640,
   parameter int PIX_W     = 8,
   parameter int ADDR_W    = $clog2(IMG_WIDTH)
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] addr,
   input  logic              wr_en,
   input  logic [PIX_W-1:0]  din,
   output logic [PIX_W-1:0]  dout
);

   // Contents need no reset: nothing read from here is emitted until the
   // whole line has been rewritten after a reset or frame start.
   logic [PIX_W-1:0] mem [IMG_WIDTH];

   assign dout = mem[addr];

   // Store the incoming pixel at the current column on each accept.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[addr] <= din;
      end
   end

endmodule
`default_nettype wire

// File: rtl/window_5x5_gen.sv
`default_nettype none
// ============================================================================
// Module      : window_5x5_gen
// Description : Streaming 5x5 window generator. Raster pixels in over a
//               valid/ready handshake, one packed 25-pixel window out per
//               accepted pixel once the window lies fully inside the image.
//               Optional macro WIN_CNT_EN adds a saturating 32-bit count of
//               completed window transfers on port win_count.
// Revision    : 1.0 - initial release
// ============================================================================
module window_5x5_gen
   import window_5x5_gen_pkg::*;
#(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int PIX_W      = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [PIX_W-1:0]         in_pixel,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [WIN_PIX*PIX_W-1:0] win_out,
   output logic                     win_valid,
   input  logic                     win_ready,
   output logic                     frame_done
`ifdef WIN_CNT_EN
   ,
   output logic [31:0]              win_count
`endif
);

   localparam int X_W   = $clog2(IMG_WIDTH);
   localparam int Y_W   = $clog2(IMG_HEIGHT);
   localparam int WIN_W = WIN_PIX * PIX_W;
   localparam int N_LB  = WIN_DIM - 1;

   logic [X_W-1:0]   x;
   logic [Y_W-1:0]   y;
   logic             accept;
   logic             x_last;
   logic             y_last;
   logic             qualify;
   logic [WIN_W-1:0] win_reg;
   logic [WIN_W-1:0] win_next;
   logic [PIX_W-1:0] new_col [WIN_DIM];
   logic [PIX_W-1:0] lb_din  [N_LB];
   logic [PIX_W-1:0] lb_dout [N_LB];

   assign in_ready = !win_valid || win_ready;
   assign accept   = in_valid && in_ready;
   assign x_last   = (x == X_W'(IMG_WIDTH - 1));
   assign y_last   = (y == Y_W'(IMG_HEIGHT - 1));
   // Only windows whose five columns all belong to the current line and
   // whose five rows all belong to the current frame are emitted.
   assign qualify  = (x >= X_W'(WIN_DIM - 1)) && (y >= Y_W'(WIN_DIM - 1));
   // rst gating keeps the pulse low while the block is held in reset.
   assign frame_done = accept && x_last && y_last && !rst;
   assign win_out  = win_reg;

   // Four chained line buffers; LB0 sees the newest line, LB3 the oldest.
   generate
      for (genvar i = 0; i < N_LB; i++) begin : g_lb
         if (i == 0) begin : g_head
            assign lb_din[i] = in_pixel;
         end else begin : g_chain
            assign lb_din[i] = lb_dout[i-1];
         end
         window_5x5_gen_line_buffer #(
            .IMG_WIDTH (IMG_WIDTH),
            .PIX_W     (PIX_W),
            .ADDR_W    (X_W)
         ) u_line_buffer (
            .clk   (clk),
            .addr  (x),
            .wr_en (accept),
            .din   (lb_din[i]),
            .dout  (lb_dout[i])
         );
      end
   endgenerate

   // Assemble the incoming column top (oldest line) to bottom (new pixel).
   always_comb begin
      for (int r = 0; r < WIN_DIM; r++) begin
         new_col[r] = '0;
      end
      for (int r = 0; r < N_LB; r++) begin
         new_col[r] = lb_dout[N_LB-1-r];
      end
      new_col[WIN_DIM-1] = in_pixel;
   end

   // Shift every row one column left and drop the new column in at the right.
   always_comb begin
      win_next = '0;
      for (int r = 0; r < WIN_DIM; r++) begin
         for (int c = 0; c < WIN_DIM - 1; c++) begin
            win_next[win_idx(r, c, PIX_W) +: PIX_W] =
               win_reg[win_idx(r, c + 1, PIX_W) +: PIX_W];
         end
         win_next[win_idx(r, WIN_DIM - 1, PIX_W) +: PIX_W] = new_col[r];
      end
   end

   // Raster position counters, advanced once per accepted pixel.
   always_ff @(posedge clk) begin
      if (rst) begin
         x <= '0;
         y <= '0;
      end else if (accept) begin
         if (x_last) begin
            x <= '0;
            y <= y_last ? '0 : y + Y_W'(1);
         end else begin
            x <= x + X_W'(1);
         end
      end
   end

   // Window register shifts on every accept, qualifying or not.
   always_ff @(posedge clk) begin
      if (rst) begin
         win_reg <= '0;
      end else if (accept) begin
         win_reg <= win_next;
      end
   end

   // Output valid: set by a qualifying accept, cleared once consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         win_valid <= 1'b0;
      end else if (accept && qualify) begin
         win_valid <= 1'b1;
      end else if (win_ready) begin
         win_valid <= 1'b0;
      end
   end

`ifdef WIN_CNT_EN
   // Saturating count of completed window transfers across frames.
   always_ff @(posedge clk) begin
      if (rst) begin
         win_count <= '0;
      end else if (win_valid && win_ready && (win_count != 32'hFFFF_FFFF)) begin
         win_count <= win_count + 32'd1;
      end
   end
`endif

endmodule
`default_nettype wire
